// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - multiplexed active-low 7-seg bus to hex frame decoder
// Optional decimal-point capture enabled by defining SEG7DEC_DP_EN.
module seg7_scan_decoder #(
  parameter int NDIG   = 4,
  parameter int STABLE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NDIG-1:0]   an,
  input  logic [6:0]        seg,
`ifdef SEG7DEC_DP_EN
  input  logic              dp,
  output logic [NDIG-1:0]   dp_out,
`endif
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   dig_err,
  output logic              frame_valid,
  output logic [7:0]        frame_cnt
);

`ifdef SEG7DEC_DP_EN
  localparam int SW = NDIG + 8;
`else
  localparam int SW = NDIG + 7;
`endif

  typedef enum logic [1:0] {S_WAIT, S_COUNT, S_HOLD} state_t;

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [SW-1:0]     sample, prev;
  logic              prev_ld, capture, an_valid, same, publish;
  logic [NDIG-1:0]   an_inv, cap_hot, seen;
  logic [4*NDIG-1:0] sh_dig, sh_dig_nxt;
  logic [NDIG-1:0]   sh_err, sh_err_nxt;
  logic [4:0]        dec;
`ifdef SEG7DEC_DP_EN
  logic [NDIG-1:0]   sh_dp, sh_dp_nxt;
  assign sample = {dp, an, seg};
`else
  assign sample = {an, seg};
`endif

  // Exactly one anode pulled low selects a digit; blank and ghosting are rejected.
  assign an_inv   = ~an;
  assign an_valid = (an_inv != '0) && ((an_inv & (an_inv - 1'b1)) == '0);
  assign same     = (sample == prev);

  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0010000: decode = 5'h09;
      7'b0001000: decode = 5'h0a;
      7'b0000011: decode = 5'h0b;
      7'b1000110: decode = 5'h0c;
      7'b0100001: decode = 5'h0d;
      7'b0000110: decode = 5'h0e;
      7'b0001110: decode = 5'h0f;
      default:    decode = 5'h10;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state <= S_WAIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    prev_ld   = 1'b0;
    capture   = 1'b0;
    case (state)
      S_WAIT: begin
        if (an_valid) begin
          state_nxt = S_COUNT;
          cnt_nxt   = 8'd1;
          prev_ld   = 1'b1;
        end
      end
      S_COUNT: begin
        if (!an_valid) begin
          state_nxt = S_WAIT;
          cnt_nxt   = 8'd0;
        end else if (same) begin
          if (cnt == 8'(STABLE - 1)) begin
            state_nxt = S_HOLD;
            cnt_nxt   = 8'd0;
            capture   = 1'b1;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end else begin
          cnt_nxt = 8'd1;
          prev_ld = 1'b1;
        end
      end
      S_HOLD: begin
        if (!same) begin
          state_nxt = an_valid ? S_COUNT : S_WAIT;
          cnt_nxt   = an_valid ? 8'd1 : 8'd0;
          prev_ld   = an_valid;
        end
      end
      default: begin
        state_nxt = S_WAIT;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // At capture the live sample equals prev, so prev supplies the digit select and glyph.
  always_comb begin
    dec        = decode(prev[6:0]);
    cap_hot    = capture ? ~prev[NDIG+6:7] : '0;
    sh_dig_nxt = sh_dig;
    sh_err_nxt = sh_err;
`ifdef SEG7DEC_DP_EN
    sh_dp_nxt  = sh_dp;
`endif
    for (int i = 0; i < NDIG; i++) begin
      if (cap_hot[i]) begin
        sh_dig_nxt[4*i +: 4] = dec[3:0];
        sh_err_nxt[i]        = dec[4];
`ifdef SEG7DEC_DP_EN
        sh_dp_nxt[i]         = ~prev[SW-1];
`endif
      end
    end
    publish = capture && ((seen | cap_hot) == {NDIG{1'b1}});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt         <= '0;
      prev        <= '0;
      seen        <= '0;
      sh_dig      <= '0;
      sh_err      <= '0;
      digits      <= '0;
      dig_err     <= '0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
`ifdef SEG7DEC_DP_EN
      sh_dp       <= '0;
      dp_out      <= '0;
`endif
    end else begin
      cnt         <= cnt_nxt;
      if (prev_ld) prev <= sample;
      sh_dig      <= sh_dig_nxt;
      sh_err      <= sh_err_nxt;
      seen        <= publish ? '0 : (seen | cap_hot);
      frame_valid <= publish;
`ifdef SEG7DEC_DP_EN
      sh_dp       <= sh_dp_nxt;
`endif
      if (publish) begin
        digits    <= sh_dig_nxt;
        dig_err   <= sh_err_nxt;
        frame_cnt <= frame_cnt + 8'd1;
`ifdef SEG7DEC_DP_EN
        dp_out    <= sh_dp_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic [3:0]  dig_err;
  logic        frame_valid;
  logic [7:0]  frame_cnt;
  int          errors = 0;
  int          checks = 0;
  int          fv_count = 0;
  int          fv_base;
`ifdef SEG7DEC_DP_EN
  logic        dp;
  logic [3:0]  dp_out;
`endif

  always #5 clk = ~clk;

  seg7_scan_decoder #(.NDIG(4), .STABLE(4)) dut (
    .clk(clk),
    .rst(rst),
    .an(an),
    .seg(seg),
`ifdef SEG7DEC_DP_EN
    .dp(dp),
    .dp_out(dp_out),
`endif
    .digits(digits),
    .dig_err(dig_err),
    .frame_valid(frame_valid),
    .frame_cnt(frame_cnt)
  );

  always @(negedge clk) if (frame_valid === 1'b1) fv_count++;

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a;
    seg = s;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    an = 4'b1111;
    seg = 7'h7f;
    rst = 1'b0;
`ifdef SEG7DEC_DP_EN
    dp = 1'b1;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    checks++; if (digits !== 16'h0) begin errors++; $display("FAIL reset_digits got=%h exp=0000", digits); end
    checks++; if (dig_err !== 4'h0) begin errors++; $display("FAIL reset_err got=%b exp=0000", dig_err); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
    checks++; if (frame_cnt !== 8'h0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", frame_cnt); end
  endtask

  task automatic test_basic_frame;
    fv_base = fv_count;
    dwell(4'b1110, 7'b1000000, 6);
    dwell(4'b1101, 7'b0100100, 6);
    dwell(4'b1011, 7'b0011001, 6);
    dwell(4'b0111, 7'b0001110, 6);
    dwell(4'b1111, 7'h7f, 2);
    checks++; if (fv_count - fv_base !== 1) begin errors++; $display("FAIL basic_pulses got=%0d exp=1", fv_count - fv_base); end
    checks++; if (digits !== 16'hF420) begin errors++; $display("FAIL basic_digits got=%h exp=f420", digits); end
    checks++; if (dig_err !== 4'b0000) begin errors++; $display("FAIL basic_err got=%b exp=0000", dig_err); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL basic_cnt got=%0d exp=1", frame_cnt); end
  endtask

  task automatic test_short_dwell;
    fv_base = fv_count;
    dwell(4'b1101, 7'b1111001, 3);
    dwell(4'b1110, 7'b1111000, 6);
    dwell(4'b1011, 7'b0000000, 6);
    dwell(4'b0111, 7'b0010000, 6);
    dwell(4'b1111, 7'h7f, 2);
    checks++; if (fv_count - fv_base !== 0) begin errors++; $display("FAIL short_nopulse got=%0d exp=0", fv_count - fv_base); end
    checks++; if (digits !== 16'hF420) begin errors++; $display("FAIL short_hold got=%h exp=f420", digits); end
    dwell(4'b1101, 7'b1111001, 4);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL short_latency got=%b exp=1", frame_valid); end
    checks++; if (digits !== 16'h9817) begin errors++; $display("FAIL short_digits got=%h exp=9817", digits); end
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL short_cnt got=%0d exp=2", frame_cnt); end
    dwell(4'b1111, 7'h7f, 1);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL short_onecycle got=%b exp=0", frame_valid); end
  endtask

  task automatic test_dash;
    fv_base = fv_count;
    dwell(4'b1110, 7'b0000010, 6);
    dwell(4'b1101, 7'b0000011, 6);
    dwell(4'b1011, 7'b0111111, 6);
    dwell(4'b0111, 7'b1000110, 6);
    dwell(4'b1111, 7'h7f, 2);
    checks++; if (fv_count - fv_base !== 1) begin errors++; $display("FAIL dash_pulses got=%0d exp=1", fv_count - fv_base); end
    checks++; if (digits !== 16'hC0B6) begin errors++; $display("FAIL dash_digits got=%h exp=c0b6", digits); end
    checks++; if (dig_err !== 4'b0100) begin errors++; $display("FAIL dash_err got=%b exp=0100", dig_err); end
  endtask

  task automatic test_invalid_an;
    fv_base = fv_count;
    dwell(4'b1101, 7'b1111001, 6);
    dwell(4'b1011, 7'b0110000, 6);
    dwell(4'b0111, 7'b0010010, 6);
    dwell(4'b1100, 7'b0001000, 20);
    dwell(4'b1111, 7'b0001000, 20);
    checks++; if (fv_count - fv_base !== 0) begin errors++; $display("FAIL inv_nopulse got=%0d exp=0", fv_count - fv_base); end
    checks++; if (digits !== 16'hC0B6) begin errors++; $display("FAIL inv_hold got=%h exp=c0b6", digits); end
    dwell(4'b1110, 7'b0001000, 3);
    dwell(4'b1111, 7'h7f, 2);
    checks++; if (fv_count - fv_base !== 0) begin errors++; $display("FAIL inv_partial got=%0d exp=0", fv_count - fv_base); end
    dwell(4'b1110, 7'b0001000, 4);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL inv_full_dwell got=%b exp=1", frame_valid); end
    checks++; if (digits !== 16'h531A) begin errors++; $display("FAIL inv_digits got=%h exp=531a", digits); end
    checks++; if (frame_cnt !== 8'd4) begin errors++; $display("FAIL inv_cnt got=%0d exp=4", frame_cnt); end
  endtask

  task automatic test_mid_frame_reset;
    dwell(4'b1110, 7'b0000110, 6);
    dwell(4'b1101, 7'b0100001, 6);
    an = 4'b1111;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checks++; if (digits !== 16'h0) begin errors++; $display("FAIL mrst_digits got=%h exp=0000", digits); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL mrst_cnt got=%0d exp=0", frame_cnt); end
    fv_base = fv_count;
    dwell(4'b1011, 7'b0100100, 6);
    dwell(4'b0111, 7'b0000000, 6);
    dwell(4'b1111, 7'h7f, 2);
    checks++; if (fv_count - fv_base !== 0) begin errors++; $display("FAIL mrst_nopulse got=%0d exp=0", fv_count - fv_base); end
    checks++; if (digits !== 16'h0) begin errors++; $display("FAIL mrst_hold got=%h exp=0000", digits); end
    dwell(4'b1110, 7'b0000110, 6);
    dwell(4'b1101, 7'b0100001, 6);
    dwell(4'b1111, 7'h7f, 2);
    checks++; if (fv_count - fv_base !== 1) begin errors++; $display("FAIL mrst_pulses got=%0d exp=1", fv_count - fv_base); end
    checks++; if (digits !== 16'h82DE) begin errors++; $display("FAIL mrst_digits2 got=%h exp=82de", digits); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL mrst_cnt2 got=%0d exp=1", frame_cnt); end
  endtask

`ifdef SEG7DEC_DP_EN
  task automatic test_dp;
    fv_base = fv_count;
    dp = 1'b1;
    dwell(4'b1110, 7'b1000000, 6);
    dwell(4'b1101, 7'b1000000, 6);
    dwell(4'b1011, 7'b1000000, 6);
    dwell(4'b0111, 7'b1000000, 2);
    dp = 1'b0;
    dwell(4'b0111, 7'b1000000, 3);
    checks++; if (fv_count - fv_base !== 0) begin errors++; $display("FAIL dp_restart got=%0d exp=0", fv_count - fv_base); end
    dwell(4'b0111, 7'b1000000, 1);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL dp_capture got=%b exp=1", frame_valid); end
    checks++; if (dp_out !== 4'b1000) begin errors++; $display("FAIL dp_out got=%b exp=1000", dp_out); end
    dp = 1'b1;
    dwell(4'b1111, 7'h7f, 2);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_short_dwell();
    test_dash();
    test_invalid_an();
    test_mid_frame_reset();
`ifdef SEG7DEC_DP_EN
    test_dp();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
